// File: rtl/duty_meter_multi.sv
// duty_meter_multi: multi-channel duty-cycle meter, sequential divide and BCD.
// Define DUTY_ROUND_EN for round-half-up percentages (default: floor).
module duty_meter_multi #(
    parameter int CHANNELS = 2,
    parameter int PRESCALE = 2500,
    parameter int WINDOW   = 200,
    parameter int CNT_W    = 16
) (
    input  logic                InputClock,
    input  logic                Reset,
    input  logic [CHANNELS-1:0] Signal,
    input  logic                DutyReady,
    output logic                DutyValid,
    output logic [3:0]          DutyChannel,
    output logic [6:0]          DutyPercent,
    output logic [11:0]         DutyBcd,
    output logic                Busy,
    output logic                Overrun
);

    localparam int NW = CNT_W + 7;
    localparam int RW = CNT_W + 1;
    localparam int SW = $clog2(NW + 1);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW - 1);
    localparam logic [RW-1:0]    DIVISOR  = RW'(WINDOW);
    localparam logic [NW-1:0]    HUNDRED  = NW'(100);
    localparam logic [SW-1:0]    DIV_LAST = SW'(NW - 1);
    localparam logic [SW-1:0]    BCD_LAST = SW'(6);
    localparam logic [3:0]       CH_LAST  = 4'(CHANNELS - 1);
`ifdef DUTY_ROUND_EN
    localparam logic [NW-1:0]    HALF     = NW'(WINDOW / 2);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DIV,
        S_BCD,
        S_PRESENT
    } state_t;

    state_t state_q, state_d;

    logic [CHANNELS-1:0] meta_q, sync_q;
    logic [PW-1:0]       pre_q, pre_d;
    logic [CNT_W-1:0]    win_q, win_d;
    logic [CNT_W-1:0]    high_q [CHANNELS];
    logic [CNT_W-1:0]    high_d [CHANNELS];
    logic [CNT_W-1:0]    snap_q [CHANNELS];
    logic [CNT_W-1:0]    snap_d [CHANNELS];

    logic [3:0]          ch_q, ch_d;
    logic [NW-1:0]       nq_q, nq_d;
    logic [CNT_W-1:0]    rem_q, rem_d;
    logic [SW-1:0]       step_q, step_d;
    logic [6:0]          bin_q, bin_d;
    logic [10:0]         bcd_q, bcd_d;
    logic [6:0]          pct_q, pct_d;
    logic                ovr_q, ovr_d;
    logic [3:0]          och_q, och_d;
    logic [6:0]          opct_q, opct_d;
    logic [11:0]         obcd_q, obcd_d;

    logic                tick;
    logic                win_end;
    logic [CNT_W-1:0]    snap_sel;
    logic [NW-1:0]       num;
    logic [RW-1:0]       trial;
    logic                take;
    logic [NW-1:0]       q_next;
    logic [3:0]          tens_a;
    logic [3:0]          ones_a;
    logic [11:0]         bcd_next;

    always_comb begin
        snap_sel = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (ch_q == 4'(i)) snap_sel = snap_q[i];
        end
    end

    // Sample counters: a window end restarts them on the same edge it samples.
    always_comb begin
        tick    = (pre_q == PRE_LAST);
        win_end = tick && (win_q == WIN_LAST);
        pre_d   = tick ? '0 : pre_q + PW'(1);
        win_d   = win_q;
        high_d  = high_q;
        if (tick) begin
            win_d = win_end ? '0 : win_q + CNT_W'(1);
            for (int i = 0; i < CHANNELS; i++) begin
                high_d[i] = win_end ? '0 : high_q[i] + CNT_W'(sync_q[i]);
            end
        end
    end

    always_comb begin
        trial    = {rem_q, nq_q[NW-1]};
        take     = (trial >= DIVISOR);
        q_next   = {nq_q[NW-2:0], take};
        tens_a   = (bcd_q[7:4] >= 4'd5) ? bcd_q[7:4] + 4'd3 : bcd_q[7:4];
        ones_a   = (bcd_q[3:0] >= 4'd5) ? bcd_q[3:0] + 4'd3 : bcd_q[3:0];
        bcd_next = {bcd_q[10:8], tens_a, ones_a, bin_q[6]};
`ifdef DUTY_ROUND_EN
        num      = NW'(snap_sel) * HUNDRED + HALF;
`else
        num      = NW'(snap_sel) * HUNDRED;
`endif
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        nq_d    = nq_q;
        rem_d   = rem_q;
        step_d  = step_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        pct_d   = pct_q;
        ovr_d   = ovr_q;
        och_d   = och_q;
        opct_d  = opct_q;
        obcd_d  = obcd_q;
        snap_d  = snap_q;

        // A busy pipeline keeps draining the old snapshot; flag the loss.
        if (win_end) begin
            if (state_q == S_IDLE) begin
                for (int i = 0; i < CHANNELS; i++) begin
                    snap_d[i] = high_q[i] + CNT_W'(sync_q[i]);
                end
                state_d = S_LOAD;
                ch_d    = '0;
            end else begin
                ovr_d = 1'b1;
            end
        end

        unique case (state_q)
            S_IDLE: begin
            end
            S_LOAD: begin
                nq_d    = num;
                rem_d   = '0;
                step_d  = '0;
                state_d = S_DIV;
            end
            S_DIV: begin
                rem_d  = take ? CNT_W'(trial - DIVISOR) : CNT_W'(trial);
                nq_d   = q_next;
                step_d = step_q + SW'(1);
                if (step_q == DIV_LAST) begin
                    pct_d   = (q_next > HUNDRED) ? 7'd100 : q_next[6:0];
                    bin_d   = (q_next > HUNDRED) ? 7'd100 : q_next[6:0];
                    bcd_d   = '0;
                    step_d  = '0;
                    state_d = S_BCD;
                end
            end
            S_BCD: begin
                bcd_d  = bcd_next[10:0];
                bin_d  = {bin_q[5:0], 1'b0};
                step_d = step_q + SW'(1);
                if (step_q == BCD_LAST) begin
                    obcd_d  = bcd_next;
                    opct_d  = pct_q;
                    och_d   = ch_q;
                    state_d = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (DutyReady) begin
                    if (ch_q == CH_LAST) begin
                        state_d = S_IDLE;
                    end else begin
                        ch_d    = ch_q + 4'd1;
                        state_d = S_LOAD;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge InputClock) begin
        if (Reset) begin
            state_q <= S_IDLE;
            meta_q  <= '0;
            sync_q  <= '0;
            pre_q   <= '0;
            win_q   <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                high_q[i] <= '0;
                snap_q[i] <= '0;
            end
            ch_q    <= '0;
            nq_q    <= '0;
            rem_q   <= '0;
            step_q  <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
            pct_q   <= '0;
            ovr_q   <= 1'b0;
            och_q   <= '0;
            opct_q  <= '0;
            obcd_q  <= '0;
        end else begin
            state_q <= state_d;
            meta_q  <= Signal;
            sync_q  <= meta_q;
            pre_q   <= pre_d;
            win_q   <= win_d;
            high_q  <= high_d;
            snap_q  <= snap_d;
            ch_q    <= ch_d;
            nq_q    <= nq_d;
            rem_q   <= rem_d;
            step_q  <= step_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            pct_q   <= pct_d;
            ovr_q   <= ovr_d;
            och_q   <= och_d;
            opct_q  <= opct_d;
            obcd_q  <= obcd_d;
        end
    end

    assign DutyValid   = (state_q == S_PRESENT);
    assign DutyChannel = och_q;
    assign DutyPercent = opct_q;
    assign DutyBcd     = obcd_q;
    assign Busy        = (state_q != S_IDLE);
    assign Overrun     = ovr_q;

endmodule
